// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the instruction/data cache memory-port arbiter:
// default bus widths, FSM state encodings and the starvation counter helper.
package mem_bus_arbiter_pkg;

  localparam int unsigned ARB_ADDR_W_DEF  = 28;
  localparam int unsigned ARB_BLOCK_W_DEF = 128;
  localparam int unsigned ARB_STARVE_W    = 4;

  // 2'b11 is unused; the FSM treats it as illegal and falls back to ARB_IDLE.
  typedef enum logic [1:0] {
    ARB_IDLE    = 2'b00,
    ARB_SERVE_D = 2'b01,
    ARB_SERVE_I = 2'b10
  } arb_state_e;

  // Saturating increment for the starvation counter.
  function automatic logic [ARB_STARVE_W-1:0] starve_inc(input logic [ARB_STARVE_W-1:0] v);
    return (v == '1) ? v : v + ARB_STARVE_W'(1);
  endfunction

endpackage

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one main-memory block port between the I-cache
// (read-only) and the D-cache (read/write). Data-first priority, one idle
// turnaround cycle between transfers, and a starvation limit that forces an
// I grant after STARVE_LIMIT consecutive D grants made while i_read waits.
// Ports:
//   CLK, RESET                   clock, synchronous active-high reset
//   i_read/i_address             I-cache block read request (level)
//   i_readdata/i_busywait        I-cache return data and stall
//   d_read/d_write/d_address/d_writedata   D-cache fill / write-back request
//   d_readdata/d_busywait        D-cache return data and stall
//   mem_read/mem_write           registered memory strobes
//   mem_address/mem_writedata    registered memory address / write block
//   mem_readdata/mem_busywait    memory return data and busy
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W       = ARB_ADDR_W_DEF,
  parameter int unsigned BLOCK_W      = ARB_BLOCK_W_DEF,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               i_read,
  input  logic [ADDR_W-1:0]  i_address,
  output logic [BLOCK_W-1:0] i_readdata,
  output logic               i_busywait,
  input  logic               d_read,
  input  logic               d_write,
  input  logic [ADDR_W-1:0]  d_address,
  input  logic [BLOCK_W-1:0] d_writedata,
  output logic [BLOCK_W-1:0] d_readdata,
  output logic               d_busywait,
  output logic               mem_read,
  output logic               mem_write,
  output logic [ADDR_W-1:0]  mem_address,
  output logic [BLOCK_W-1:0] mem_writedata,
  input  logic [BLOCK_W-1:0] mem_readdata,
  input  logic               mem_busywait
);

  localparam logic [ARB_STARVE_W-1:0] LIMIT_C = ARB_STARVE_W'(STARVE_LIMIT);

  arb_state_e                state_q, state_d;
  logic [ARB_STARVE_W-1:0]   starve_q, starve_d;
  logic                      mem_read_q, mem_read_d;
  logic                      mem_write_q, mem_write_d;
  logic [ADDR_W-1:0]         mem_address_q, mem_address_d;
  logic [BLOCK_W-1:0]        mem_writedata_q, mem_writedata_d;
  logic                      d_req;
  logic                      i_done;
  logic                      d_done;

  assign d_req = d_read | d_write;

  // Completion is only recognised out of reset so stalls follow the requests during reset.
  assign i_done = ~RESET & (state_q == ARB_SERVE_I) & ~mem_busywait;
  assign d_done = ~RESET & (state_q == ARB_SERVE_D) & ~mem_busywait;

  assign i_busywait = i_read & ~i_done;
  assign d_busywait = d_req  & ~d_done;

  // Read data is a shared bus; each cache samples it only in its own completion cycle.
  assign i_readdata = mem_readdata;
  assign d_readdata = mem_readdata;

  assign mem_read      = mem_read_q;
  assign mem_write     = mem_write_q;
  assign mem_address   = mem_address_q;
  assign mem_writedata = mem_writedata_q;

  // State and latch registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q         <= ARB_IDLE;
      starve_q        <= '0;
      mem_read_q      <= 1'b0;
      mem_write_q     <= 1'b0;
      mem_address_q   <= '0;
      mem_writedata_q <= '0;
    end else begin
      state_q         <= state_d;
      starve_q        <= starve_d;
      mem_read_q      <= mem_read_d;
      mem_write_q     <= mem_write_d;
      mem_address_q   <= mem_address_d;
      mem_writedata_q <= mem_writedata_d;
    end
  end

  // Arbitration, strobe generation and starvation tracking.
  always_comb begin
    state_d         = state_q;
    starve_d        = starve_q;
    mem_read_d      = mem_read_q;
    mem_write_d     = mem_write_q;
    mem_address_d   = mem_address_q;
    mem_writedata_d = mem_writedata_q;

    unique case (state_q)
      ARB_IDLE: begin
        if (d_req && !(i_read && (starve_q >= LIMIT_C))) begin
          state_d       = ARB_SERVE_D;
          // A simultaneous read+write is issued as a write-back.
          mem_write_d   = d_write;
          mem_read_d    = ~d_write;
          mem_address_d = d_address;
          if (d_write) begin
            mem_writedata_d = d_writedata;
          end
          starve_d = i_read ? starve_inc(starve_q) : '0;
        end else if (i_read) begin
          state_d       = ARB_SERVE_I;
          mem_read_d    = 1'b1;
          mem_write_d   = 1'b0;
          mem_address_d = i_address;
          starve_d      = '0;
        end else begin
          starve_d = '0;
        end
      end
      ARB_SERVE_D, ARB_SERVE_I: begin
        // No preemption: hold the grant until memory finishes.
        if (!mem_busywait) begin
          state_d     = ARB_IDLE;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
        end
      end
      default: begin
        state_d     = ARB_IDLE;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed latency/priority scenarios
// plus a randomized run checked against a transfer-level reference model.
module tb_mem_bus_arbiter;
  import mem_bus_arbiter_pkg::*;

  localparam int unsigned AW  = 28;
  localparam int unsigned BW  = 128;
  localparam int unsigned LIM = 4;

  logic          CLK = 1'b0;
  logic          RESET;
  logic          i_read;
  logic [AW-1:0] i_address;
  logic [BW-1:0] i_readdata;
  logic          i_busywait;
  logic          d_read;
  logic          d_write;
  logic [AW-1:0] d_address;
  logic [BW-1:0] d_writedata;
  logic [BW-1:0] d_readdata;
  logic          d_busywait;
  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] mem_address;
  logic [BW-1:0] mem_writedata;
  logic [BW-1:0] mem_readdata;
  logic          mem_busywait;

  int checks     = 0;
  int failures   = 0;
  int lat        = 5;
  int elapsed    = 0;
  int proto_errs = 0;

  always #5 CLK = ~CLK;

  mem_bus_arbiter #(
    .ADDR_W(AW), .BLOCK_W(BW), .STARVE_LIMIT(LIM)
  ) dut (
    .CLK(CLK), .RESET(RESET),
    .i_read(i_read), .i_address(i_address), .i_readdata(i_readdata), .i_busywait(i_busywait),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_writedata(d_writedata),
    .d_readdata(d_readdata), .d_busywait(d_busywait),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_writedata(mem_writedata), .mem_readdata(mem_readdata), .mem_busywait(mem_busywait)
  );

  // Memory contents are a fixed function of the block address.
  function automatic logic [BW-1:0] pattern(input logic [AW-1:0] a);
    return {4'h0, a, 4'hC, ~a, 32'hDEAD_0000 | 32'(a[15:0]), 4'h5, a};
  endfunction

  // Memory: busy for 'lat' cycles starting in the strobe cycle, then done.
  assign mem_busywait = (mem_read | mem_write) && (elapsed < lat);
  assign mem_readdata = pattern(mem_address);

  always @(posedge CLK) begin
    if (RESET || !(mem_read || mem_write) || !mem_busywait) elapsed <= 0;
    else elapsed <= elapsed + 1;
  end

  // Protocol checker: simultaneous D read and write is a requester error.
  always @(posedge CLK) begin
    if (!RESET && d_read && d_write) proto_errs <= proto_errs + 1;
  end

  task automatic clear_inputs();
    i_read = 1'b0; i_address = '0;
    d_read = 1'b0; d_write = 1'b0; d_address = '0; d_writedata = '0;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    clear_inputs();
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b0;
  endtask

  task automatic settle();
    @(posedge CLK); #1;
    clear_inputs();
    repeat (5) @(posedge CLK);
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    i_read = 1'b1; i_address = 28'h00000AB;
    d_read = 1'b0; d_write = 1'b1; d_address = 28'h0000CD; d_writedata = {4{32'h1234_5678}};
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    checks++; if (mem_read !== 1'b0) begin failures++; $display("FAIL reset_mem_read: got %0b expected 0", mem_read); end
    checks++; if (mem_write !== 1'b0) begin failures++; $display("FAIL reset_mem_write: got %0b expected 0", mem_write); end
    checks++; if (mem_address !== '0) begin failures++; $display("FAIL reset_mem_address: got %0h expected 0", mem_address); end
    checks++; if (mem_writedata !== '0) begin failures++; $display("FAIL reset_mem_writedata: got %0h expected 0", mem_writedata); end
    checks++; if (i_busywait !== 1'b1) begin failures++; $display("FAIL reset_i_busywait: got %0b expected 1", i_busywait); end
    checks++; if (d_busywait !== 1'b1) begin failures++; $display("FAIL reset_d_busywait: got %0b expected 1", d_busywait); end
    i_read = 1'b0; d_write = 1'b0;
    #1;
    checks++; if (i_busywait !== 1'b0) begin failures++; $display("FAIL reset_i_busywait_low: got %0b expected 0", i_busywait); end
    checks++; if (d_busywait !== 1'b0) begin failures++; $display("FAIL reset_d_busywait_low: got %0b expected 0", d_busywait); end
    do_reset();
  endtask

  task automatic test_reset_mid_serve();
    lat = 5;
    for (int c = 0; c < 6; c++) begin
      @(posedge CLK); #1;
      d_read = (c <= 2); d_address = 28'h0000444;
      RESET  = (c == 2);
      @(negedge CLK);
      if (c == 1 || c == 2) begin
        checks++; if (mem_read !== 1'b1) begin failures++; $display("FAIL rst_mid_strobe c=%0d: got %0b expected 1", c, mem_read); end
      end
      if (c == 2) begin
        checks++; if (d_busywait !== 1'b1) begin failures++; $display("FAIL rst_mid_d_busywait: got %0b expected 1", d_busywait); end
      end
      if (c >= 3) begin
        checks++; if (mem_read !== 1'b0 || mem_write !== 1'b0) begin failures++; $display("FAIL rst_mid_strobes c=%0d: got r=%0b w=%0b expected 0", c, mem_read, mem_write); end
        checks++; if (mem_address !== '0) begin failures++; $display("FAIL rst_mid_address c=%0d: got %0h expected 0", c, mem_address); end
      end
    end
    settle();
  endtask

  task automatic test_single_i_read();
    logic exp_rd, exp_bw;
    lat = 5;
    for (int c = 0; c < 10; c++) begin
      @(posedge CLK); #1;
      i_read = (c <= 6); i_address = 28'h0000010;
      @(negedge CLK);
      exp_rd = (c >= 1 && c <= 6);
      exp_bw = (c <= 5);
      checks++; if (mem_read !== exp_rd) begin failures++; $display("FAIL single_i_mem_read c=%0d: got %0b expected %0b", c, mem_read, exp_rd); end
      checks++; if (i_busywait !== exp_bw) begin failures++; $display("FAIL single_i_busywait c=%0d: got %0b expected %0b", c, i_busywait, exp_bw); end
      checks++; if (mem_write !== 1'b0) begin failures++; $display("FAIL single_i_mem_write c=%0d: got %0b expected 0", c, mem_write); end
      if (c == 6) begin
        checks++; if (i_readdata !== pattern(28'h0000010)) begin failures++; $display("FAIL single_i_readdata: got %0h expected %0h", i_readdata, pattern(28'h0000010)); end
        checks++; if (mem_address !== 28'h0000010) begin failures++; $display("FAIL single_i_address: got %0h expected 10", mem_address); end
      end
    end
    settle();
  endtask

  task automatic test_d_write_then_i();
    logic [BW-1:0] wd;
    logic exp_w, exp_r, exp_ib, exp_db;
    int i_stall;
    lat = 5; wd = {$urandom, $urandom, $urandom, $urandom}; i_stall = 0;
    for (int c = 0; c < 16; c++) begin
      @(posedge CLK); #1;
      d_write = (c <= 6); d_address = 28'h0ABCDEF; d_writedata = wd;
      i_read  = (c <= 13); i_address = 28'h0000200;
      @(negedge CLK);
      exp_w  = (c >= 1 && c <= 6);
      exp_r  = (c >= 8 && c <= 13);
      exp_db = (c <= 5);
      exp_ib = (c <= 12);
      if (i_busywait) i_stall++;
      checks++; if (mem_write !== exp_w) begin failures++; $display("FAIL dthen_i_mem_write c=%0d: got %0b expected %0b", c, mem_write, exp_w); end
      checks++; if (mem_read !== exp_r) begin failures++; $display("FAIL dthen_i_mem_read c=%0d: got %0b expected %0b", c, mem_read, exp_r); end
      checks++; if (d_busywait !== exp_db) begin failures++; $display("FAIL dthen_i_d_busywait c=%0d: got %0b expected %0b", c, d_busywait, exp_db); end
      checks++; if (i_busywait !== exp_ib) begin failures++; $display("FAIL dthen_i_i_busywait c=%0d: got %0b expected %0b", c, i_busywait, exp_ib); end
      if (c == 1) begin
        checks++; if (mem_writedata !== wd || mem_address !== 28'h0ABCDEF) begin failures++; $display("FAIL dthen_i_write_latch: got a=%0h d=%0h expected a=abcdef d=%0h", mem_address, mem_writedata, wd); end
      end
      if (c == 13) begin
        checks++; if (i_readdata !== pattern(28'h0000200) || mem_address !== 28'h0000200) begin failures++; $display("FAIL dthen_i_read: got a=%0h d=%0h expected a=200", mem_address, i_readdata); end
      end
    end
    checks++; if (i_stall != 13) begin failures++; $display("FAIL dthen_i_stall_cycles: got %0d expected 13", i_stall); end
    settle();
  endtask

  task automatic test_starvation();
    int  g;
    bit  ps, s, exp_i, got_i;
    lat = 1; g = 0; ps = 1'b0;
    for (int c = 0; c < 100 && g < 10; c++) begin
      @(posedge CLK); #1;
      d_read = 1'b1; d_address = 28'h0D0D0D0;
      i_read = 1'b1; i_address = 28'h0101010;
      @(negedge CLK);
      s = mem_read | mem_write;
      if (s && !ps) begin
        exp_i = ((g % 5) == 4);
        got_i = (mem_address == 28'h0101010);
        checks++; if (got_i !== exp_i) begin failures++; $display("FAIL starve_grant_%0d: got owner_i=%0b expected %0b", g, got_i, exp_i); end
        g++;
      end
      ps = s;
    end
    checks++; if (g != 10) begin failures++; $display("FAIL starve_grant_count: got %0d expected 10", g); end
    settle();
  endtask

  task automatic test_zero_latency();
    logic exp_rd, exp_ib, exp_db;
    lat = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge CLK); #1;
      d_read = (c <= 1); d_address = 28'h0000AAA;
      i_read = (c <= 3); i_address = 28'h0000BBB;
      @(negedge CLK);
      exp_rd = (c == 1 || c == 3);
      exp_db = (c == 0);
      exp_ib = (c <= 2);
      checks++; if (mem_read !== exp_rd) begin failures++; $display("FAIL zero_lat_mem_read c=%0d: got %0b expected %0b", c, mem_read, exp_rd); end
      checks++; if (d_busywait !== exp_db) begin failures++; $display("FAIL zero_lat_d_busywait c=%0d: got %0b expected %0b", c, d_busywait, exp_db); end
      checks++; if (i_busywait !== exp_ib) begin failures++; $display("FAIL zero_lat_i_busywait c=%0d: got %0b expected %0b", c, i_busywait, exp_ib); end
      if (c == 1) begin
        checks++; if (mem_address !== 28'h0000AAA || d_readdata !== pattern(28'h0000AAA)) begin failures++; $display("FAIL zero_lat_d_xfer: got a=%0h expected aaa", mem_address); end
      end
      if (c == 3) begin
        checks++; if (mem_address !== 28'h0000BBB || i_readdata !== pattern(28'h0000BBB)) begin failures++; $display("FAIL zero_lat_i_xfer: got a=%0h expected bbb", mem_address); end
      end
    end
    settle();
  endtask

  task automatic test_both_rw();
    logic [BW-1:0] wd;
    int pe0;
    lat = 2; wd = {$urandom, $urandom, $urandom, $urandom}; pe0 = proto_errs;
    for (int c = 0; c < 6; c++) begin
      @(posedge CLK); #1;
      d_read = (c <= 3); d_write = (c <= 3); d_address = 28'h1234567; d_writedata = wd;
      @(negedge CLK);
      if (c == 1) begin
        checks++; if (mem_write !== 1'b1 || mem_read !== 1'b0) begin failures++; $display("FAIL both_rw_strobes: got r=%0b w=%0b expected r=0 w=1", mem_read, mem_write); end
        checks++; if (mem_address !== 28'h1234567 || mem_writedata !== wd) begin failures++; $display("FAIL both_rw_latch: got a=%0h d=%0h expected a=1234567 d=%0h", mem_address, mem_writedata, wd); end
      end
      if (c == 3) begin
        checks++; if (d_busywait !== 1'b0) begin failures++; $display("FAIL both_rw_done: got d_busywait=%0b expected 0", d_busywait); end
      end
    end
    checks++; if (proto_errs <= pe0) begin failures++; $display("FAIL both_rw_proto_flag: got %0d errors expected > %0d", proto_errs, pe0); end
    settle();
  endtask

  // Random traffic against a transfer-level model: 'owner' is who holds the
  // memory port (0 none, 1 D, 2 I); 'streak' counts D grants given while I waited.
  task automatic test_random(input int l, input int n);
    int owner, streak, i_wait, d_wait;
    bit m_wr, p_i, p_dr, p_dw, p_bw, i_done, d_done, pd;
    logic [AW-1:0] m_addr, p_ia, p_da;
    logic [BW-1:0] m_wdata, p_dwd;
    logic exp_rd, exp_wr, exp_ib, exp_db;
    lat = l;
    do_reset();
    owner = 0; streak = 0; m_wr = 0; m_addr = '0; m_wdata = '0;
    p_i = 0; p_dr = 0; p_dw = 0; p_bw = 0; p_ia = '0; p_da = '0; p_dwd = '0;
    i_done = 0; d_done = 0; i_wait = 0; d_wait = 0;
    for (int c = 0; c < n; c++) begin
      @(posedge CLK);
      if (owner == 0) begin
        pd = p_dr | p_dw;
        if (pd && !(p_i && streak >= int'(LIM))) begin
          owner = 1; m_wr = p_dw; m_addr = p_da;
          if (p_dw) m_wdata = p_dwd;
          streak = p_i ? ((streak < 15) ? streak + 1 : 15) : 0;
        end else if (p_i) begin
          owner = 2; m_wr = 0; m_addr = p_ia; streak = 0;
        end else begin
          streak = 0;
        end
      end else if (!p_bw) begin
        owner = 0;
      end
      #1;
      if (i_read && i_done) i_read = 1'b0;
      else if (!i_read && $urandom_range(0, 2) == 0) begin i_read = 1'b1; i_address = AW'($urandom); end
      if ((d_read || d_write) && d_done) begin d_read = 1'b0; d_write = 1'b0; end
      else if (!(d_read || d_write) && $urandom_range(0, 1) == 0) begin
        if ($urandom_range(0, 1) == 1) d_write = 1'b1; else d_read = 1'b1;
        d_address = AW'($urandom); d_writedata = {$urandom, $urandom, $urandom, $urandom};
      end
      @(negedge CLK);
      exp_rd = (owner == 2) || (owner == 1 && !m_wr);
      exp_wr = (owner == 1) && m_wr;
      exp_ib = i_read && !(owner == 2 && !mem_busywait);
      exp_db = (d_read || d_write) && !(owner == 1 && !mem_busywait);
      checks++; if (mem_read !== exp_rd) begin failures++; $display("FAIL rand_mem_read c=%0d: got %0b expected %0b", c, mem_read, exp_rd); end
      checks++; if (mem_write !== exp_wr) begin failures++; $display("FAIL rand_mem_write c=%0d: got %0b expected %0b", c, mem_write, exp_wr); end
      checks++; if (i_busywait !== exp_ib) begin failures++; $display("FAIL rand_i_busywait c=%0d: got %0b expected %0b", c, i_busywait, exp_ib); end
      checks++; if (d_busywait !== exp_db) begin failures++; $display("FAIL rand_d_busywait c=%0d: got %0b expected %0b", c, d_busywait, exp_db); end
      if (owner != 0) begin
        checks++; if (mem_address !== m_addr) begin failures++; $display("FAIL rand_mem_address c=%0d: got %0h expected %0h", c, mem_address, m_addr); end
      end
      if (owner == 1 && m_wr) begin
        checks++; if (mem_writedata !== m_wdata) begin failures++; $display("FAIL rand_mem_writedata c=%0d: got %0h expected %0h", c, mem_writedata, m_wdata); end
      end
      if (owner == 2 && !mem_busywait) begin
        checks++; if (i_readdata !== pattern(m_addr)) begin failures++; $display("FAIL rand_i_readdata c=%0d: got %0h expected %0h", c, i_readdata, pattern(m_addr)); end
      end
      if (owner == 1 && !m_wr && !mem_busywait) begin
        checks++; if (d_readdata !== pattern(m_addr)) begin failures++; $display("FAIL rand_d_readdata c=%0d: got %0h expected %0h", c, d_readdata, pattern(m_addr)); end
      end
      i_done = i_read && !i_busywait;
      d_done = (d_read || d_write) && !d_busywait;
      i_wait = i_busywait ? i_wait + 1 : 0;
      d_wait = d_busywait ? d_wait + 1 : 0;
      if (i_wait == 80) begin checks++; failures++; $display("FAIL rand_i_timeout c=%0d: got wait %0d expected < 80", c, i_wait); end
      if (d_wait == 80) begin checks++; failures++; $display("FAIL rand_d_timeout c=%0d: got wait %0d expected < 80", c, d_wait); end
      p_i = i_read; p_ia = i_address; p_dr = d_read; p_dw = d_write; p_da = d_address; p_dwd = d_writedata;
      p_bw = mem_busywait;
    end
    settle();
  endtask

  initial begin
    clear_inputs();
    RESET = 1'b1;
    test_reset();
    test_reset_mid_serve();
    test_single_i_read();
    test_d_write_then_i();
    test_starvation();
    test_zero_latency();
    test_both_rw();
    test_random(2, 300);
    test_random(0, 200);
    test_random(4, 200);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
